pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It merges three sources into one consistent set of pipeline-register controls: the load-use stall bit from the hazard detector, branch-taken from the ID stage, and the data-memory handshake from the MEM stage. It sits beside the hazard detector at CPU top level. It also keeps saturating performance counters and flags a data-memory timeout.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding
// and default parameter values.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int DEF_TO_W        = 8;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk_i) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, branch-taken and data-memory wait
// into pipeline-register controls, with performance counters and a timeout trap.
//
// state    | meaning
// RUN      | normal issue; load-use stall and branch flush handled here
// MEM_WAIT | pipeline frozen waiting for dmem_ack_i, wait counter running
// ERROR    | memory timeout, everything held, sticky until rst_i
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = DEF_TO_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_bit_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             error_o,
    output logic [CNT_W-1:0] load_use_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              error_q;
    logic              freeze;
    logic              lu_inc, mw_inc, fl_inc;

    assign freeze  = dmem_req_i && !dmem_ack_i;
    assign error_o = error_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= (state_d == ST_ERROR);
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        ex_mem_write_o  = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        lu_inc          = 1'b0;
        mw_inc          = 1'b0;
        fl_inc          = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze) begin
                        mem_wb_bubble_o = 1'b1;
                        mw_inc          = 1'b1;
                        if (state_q == ST_RUN) begin
                            state_d = ST_MEM_WAIT;
                            wait_d  = TO_W'(1);
                        end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
                            state_d = ST_ERROR;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end else begin
                        // Branch operands are not ready under a load-use stall,
                        // so the flush is suppressed rather than merged.
                        state_d        = ST_RUN;
                        wait_d         = '0;
                        pc_write_o     = !stall_bit_i;
                        if_id_write_o  = !stall_bit_i;
                        ex_mem_write_o = 1'b1;
                        id_ex_bubble_o = stall_bit_i;
                        if_id_flush_o  = !stall_bit_i && branch_taken_i;
                        lu_inc         = stall_bit_i;
                        fl_inc         = !stall_bit_i && branch_taken_i;
                    end
                end
                default: state_d = ST_ERROR;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .clk_i (clk_i),
        .clear (rst_i),
        .inc   (lu_inc),
        .count (load_use_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
        .clk_i (clk_i),
        .clear (rst_i),
        .inc   (mw_inc),
        .count (mem_wait_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clear (rst_i),
        .inc   (fl_inc),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios then constrained-random
// traffic, all checked every cycle against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, stall_bit, branch_taken, dmem_req, dmem_ack;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic          ex_mem_write, mem_wb_bubble, error;
    logic [CW-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    // model state: error flag, consecutive frozen cycles, counters
    bit m_err = 1'b0;
    int m_k   = 0;
    int m_lu  = 0;
    int m_mw  = 0;
    int m_fl  = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_bit_i     (stall_bit),
        .branch_taken_i  (branch_taken),
        .dmem_req_i      (dmem_req),
        .dmem_ack_i      (dmem_ack),
        .pc_write_o      (pc_write),
        .if_id_write_o   (if_id_write),
        .if_id_flush_o   (if_id_flush),
        .id_ex_bubble_o  (id_ex_bubble),
        .ex_mem_write_o  (ex_mem_write),
        .mem_wb_bubble_o (mem_wb_bubble),
        .error_o         (error),
        .load_use_cnt_o  (load_use_cnt),
        .mem_wait_cnt_o  (mem_wait_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Apply one cycle of inputs, check at the falling edge, advance model.
    task automatic cyc(input bit r, input bit req, input bit ack, input bit st, input bit br);
        bit frz;
        bit e_pc, e_ifw, e_fl, e_bub, e_exw, e_mwb;
        rst = r; dmem_req = req; dmem_ack = ack; stall_bit = st; branch_taken = br;
        frz = req && !ack;
        {e_pc, e_ifw, e_fl, e_bub, e_exw, e_mwb} = '0;
        if (!r && !m_err) begin
            if (frz) begin
                e_mwb = 1'b1;
            end else if (st) begin
                e_exw = 1'b1;
                e_bub = 1'b1;
            end else begin
                e_pc  = 1'b1;
                e_ifw = 1'b1;
                e_exw = 1'b1;
                e_fl  = br;
            end
        end
        @(negedge clk);
        chk("pc_write", pc_write, e_pc);
        chk("if_id_write", if_id_write, e_ifw);
        chk("if_id_flush", if_id_flush, e_fl);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("ex_mem_write", ex_mem_write, e_exw);
        chk("mem_wb_bubble", mem_wb_bubble, e_mwb);
        chk("error", error, m_err);
        chk("load_use_cnt", load_use_cnt, m_lu);
        chk("mem_wait_cnt", mem_wait_cnt, m_mw);
        chk("flush_cnt", flush_cnt, m_fl);
        if (r) begin
            m_err = 1'b0; m_k = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        end else if (!m_err) begin
            if (frz) begin
                if (m_k >= TIMEOUT) m_err = 1'b1;
                m_k++;
                m_mw = sat_inc(m_mw);
            end else begin
                m_k = 0;
                if (st) m_lu = sat_inc(m_lu);
                else if (br) m_fl = sat_inc(m_fl);
            end
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        bit pend;
        bit r, req, ack, st, br;
        rst = 1'b1; stall_bit = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        // single load-use stall
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lu_after_one_stall", load_use_cnt, 1);
        // branch alone, then branch under stall
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_cnt_once", flush_cnt, 1);
        // three-cycle memory wait, ack on the fourth
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mem_wait_three", mem_wait_cnt, 3);
        // same-cycle ack, and stall raised during a freeze
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mem_wait_five", mem_wait_cnt, 5);
        // timeout with no ack, then sticky ERROR, then reset recovery
        for (int i = 0; i < TIMEOUT + 1; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 1);
        chk("error_sticky", error, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("error_cleared", error, 0);
        // saturation of the load-use counter
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lu_saturated", load_use_cnt, CMAX);
        // randomized traffic honouring the held-request protocol
        pend = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            req = pend || ($urandom_range(0, 2) == 0);
            ack = req && ($urandom_range(0, 2) == 0);
            st  = $urandom_range(0, 3) == 0;
            br  = $urandom_range(0, 3) == 0;
            cyc(r, req, ack, st, br);
            pend = req && !ack && !r;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
